// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter FSM states and frame constants.
package uart_pkg;

  localparam int UART_BYTE_W     = 8;
  localparam int UART_FRAME_BITS = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_WAIT_DONE
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational rotating-priority picker: searches upward from last_grant+1 with
// wrap and returns the first active request as one-hot, index and any flag.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    logic [IDX_W-1:0] cand;
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % N);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UartTx among NUM_REQ requesters; a grant is
// held for a whole packet, with a hold timeout and a busy-acknowledge check.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int TIMEOUT  = 4096,
  parameter int ACK_WAIT = 4
) (
  input  logic                           clk,
  input  logic                           nrst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [UART_BYTE_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [UART_BYTE_W-1:0]         tx_data,
  output logic                           tx_latch,
  input  logic                           tx_busy,
  output logic                           grant_active,
  output logic [$clog2(NUM_REQ)-1:0]     grant_idx,
  output logic                           lock_abort,
  output logic                           tx_err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int HC_W  = $clog2(TIMEOUT + 1);
  localparam int AC_W  = $clog2(ACK_WAIT + 1);
  localparam logic [HC_W-1:0]  HOLD_LIMIT = HC_W'(TIMEOUT - 1);
  localparam logic [AC_W-1:0]  ACK_LIMIT  = AC_W'(ACK_WAIT - 1);
  localparam logic [IDX_W-1:0] LAST_INIT  = IDX_W'(NUM_REQ - 1);

  arb_state_e             state, state_nxt;
  logic                   lock;
  logic [IDX_W-1:0]       last_grant;
  logic [HC_W-1:0]        hold_cnt;
  logic [AC_W-1:0]        ack_cnt;

  logic [NUM_REQ-1:0]     pick_gnt;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;

  logic [NUM_REQ-1:0]     sel;
  logic                   accept;
  logic [IDX_W-1:0]       acc_idx;
  logic [UART_BYTE_W-1:0] acc_data;
  logic                   acc_last;
  logic                   owner_valid;
  logic                   abort_fire;
  logic                   ack_fail;
  logic                   done;

  logic [UART_BYTE_W-1:0] req_byte [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign req_byte[g] = req_data[UART_BYTE_W*g +: UART_BYTE_W];
  end

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req        (req_valid),
    .last_grant (last_grant),
    .gnt        (pick_gnt),
    .idx        (pick_idx),
    .any        (pick_any)
  );

  assign owner_valid = req_valid[grant_idx];

  // Accept path: combinational from req_valid / tx_busy
  always_comb begin
    sel = '0;
    if (state == ST_IDLE && pick_any) begin
      sel = pick_gnt;
    end else if (state == ST_HOLD) begin
      sel = NUM_REQ'(1) << grant_idx;
    end
    req_ready = '0;
    if ((state == ST_IDLE || state == ST_HOLD) && !tx_busy) begin
      req_ready = req_valid & sel;
    end
    accept   = |req_ready;
    acc_idx  = (state == ST_HOLD) ? grant_idx : pick_idx;
    acc_data = req_byte[acc_idx];
    acc_last = req_last[acc_idx];
  end

  always_comb begin
    state_nxt  = state;
    abort_fire = 1'b0;
    ack_fail   = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_ISSUE;
      end
      ST_HOLD: begin
        // An owner byte in the timeout cycle still wins over the abort
        if (accept) begin
          state_nxt = ST_ISSUE;
        end else if (!owner_valid && hold_cnt == HOLD_LIMIT) begin
          abort_fire = 1'b1;
          state_nxt  = ST_IDLE;
        end
      end
      ST_ISSUE: state_nxt = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (tx_busy) begin
          state_nxt = ST_WAIT_DONE;
        end else if (ack_cnt >= ACK_LIMIT) begin
          ack_fail = 1'b1;
          done     = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) done = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (done) state_nxt = lock ? ST_HOLD : ST_IDLE;
  end

  // Registered state, grant bookkeeping and output pulses
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state        <= ST_IDLE;
      lock         <= 1'b0;
      last_grant   <= LAST_INIT;
      grant_idx    <= '0;
      grant_active <= 1'b0;
      tx_latch     <= 1'b0;
      lock_abort   <= 1'b0;
      tx_err       <= 1'b0;
    end else begin
      state      <= state_nxt;
      tx_latch   <= accept;
      lock_abort <= abort_fire;
      tx_err     <= ack_fail;
      if (accept) begin
        grant_idx    <= acc_idx;
        last_grant   <= acc_idx;
        grant_active <= 1'b1;
        lock         <= !acc_last;
      end else if (abort_fire) begin
        lock         <= 1'b0;
        grant_active <= 1'b0;
      end else if (done && !lock) begin
        grant_active <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hold_cnt <= '0;
      ack_cnt  <= '0;
    end else begin
      if (state == ST_HOLD && !owner_valid) hold_cnt <= hold_cnt + 1'b1;
      else                                  hold_cnt <= '0;
      if (state == ST_ISSUE || state == ST_WAIT_ACK) ack_cnt <= ack_cnt + 1'b1;
      else                                           ack_cnt <= '0;
    end
  end

  // tx_data only changes on accept and otherwise holds the last byte sent
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tx_data <= '0;
    end else if (accept) begin
      tx_data <= acc_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small UartTx busy model.
module tb_uart_tx_arbiter;

  localparam int NREQ  = 4;
  localparam int FRAME = 8;

  logic            clk;
  logic            nrst;
  logic [NREQ-1:0] req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0] req_last;
  logic [NREQ-1:0] req_ready;
  logic [7:0]      tx_data;
  logic            tx_latch;
  logic            tx_busy;
  logic            grant_active;
  logic [1:0]      grant_idx;
  logic            lock_abort;
  logic            tx_err;

  logic            model_en;
  int              busy_cnt;
  logic [7:0]      line_mem [0:63];
  int              line_n;

  int n_chk;
  int n_err;

  uart_tx_arbiter #(
    .NUM_REQ  (NREQ),
    .TIMEOUT  (16),
    .ACK_WAIT (4)
  ) dut (
    .clk          (clk),
    .nrst         (nrst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .tx_data      (tx_data),
    .tx_latch     (tx_latch),
    .tx_busy      (tx_busy),
    .grant_active (grant_active),
    .grant_idx    (grant_idx),
    .lock_abort   (lock_abort),
    .tx_err       (tx_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // UartTx model: busy rises the cycle after a latch and stays up for FRAME cycles
  always @(posedge clk) begin
    if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    else if (model_en && tx_latch) busy_cnt <= FRAME;
  end
  assign tx_busy = (busy_cnt != 0);

  always @(posedge clk) begin
    if (tx_latch && line_n < 64) begin
      line_mem[line_n] <= tx_data;
      line_n <= line_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    tick();
    tick();
    nrst = 1'b1;
    tick();
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    #1;
    while (req_ready == '0 && n < 200) begin
      tick();
      #1;
      n++;
    end
    chk(tag, 32'(req_ready != '0), 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((grant_active || tx_busy) && n < 300) begin
      tick();
      n++;
    end
    chk("drain_idle", 32'(grant_active || tx_busy), 0);
    tick();
  endtask

  task automatic set_byte(input int i, input logic [7:0] b, input logic last);
    req_data[8*i +: 8] = b;
    req_last[i]        = last;
  endtask

  function automatic int oh2idx(input logic [NREQ-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    logic bad;
    n_chk     = 0;
    n_err     = 0;
    busy_cnt  = 0;
    line_n    = 0;
    model_en  = 1'b0;
    nrst      = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;

    // Reset values
    tick(); tick(); tick();
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_latch", tx_latch, 0);
    chk("rst_grant_active", grant_active, 0);
    chk("rst_grant_idx", grant_idx, 0);
    chk("rst_lock_abort", lock_abort, 0);
    chk("rst_tx_err", tx_err, 0);
    chk("rst_req_ready", req_ready, 0);
    nrst = 1'b1;
    tick();

    // Single byte 0x55 from req0
    model_en = 1'b1;
    set_byte(0, 8'h55, 1'b1);
    req_valid = 4'b0001;
    #1;
    chk("b1_ready_T", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    #1;
    chk("b1_latch_T1", tx_latch, 1);
    chk("b1_data_T1", tx_data, 8'h55);
    chk("b1_grant_T1", grant_active, 1);
    chk("b1_idx_T1", grant_idx, 0);
    tick();
    chk("b1_latch_T2", tx_latch, 0);
    chk("b1_busy_T2", tx_busy, 1);
    n = 0;
    while (tx_busy && n < 100) begin tick(); n++; end
    chk("b1_grant_at_busy_drop", grant_active, 1);
    tick();
    chk("b1_grant_after_drop", grant_active, 0);
    chk("b1_data_holds", tx_data, 8'h55);
    wait_idle();

    // Round-robin with all four continuously valid
    do_reset();
    base = line_n;
    for (int i = 0; i < NREQ; i++) set_byte(i, 8'hA0 + 8'(i), 1'b1);
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      wait_ready("rr_wait");
      chk("rr_onehot", $countones(req_ready), 1);
      chk("rr_order", oh2idx(req_ready), k % NREQ);
      tick();
    end
    req_valid = '0;
    wait_idle();
    chk("rr_line_count", line_n - base, 6);
    chk("rr_line_5", line_mem[base + 5], 8'hA1);

    // Packet A1,A2,A3 from req1 while req0 keeps requesting
    do_reset();
    base = line_n;
    set_byte(1, 8'hA1, 1'b0);
    req_valid = 4'b0010;
    wait_ready("pkt_wait1");
    chk("pkt_ready1", req_ready, 4'b0010);
    tick();
    chk("pkt_owner1", grant_idx, 1);
    set_byte(0, 8'h0E, 1'b1);
    set_byte(1, 8'hA2, 1'b0);
    req_valid = 4'b0011;
    wait_ready("pkt_wait2");
    chk("pkt_ready2", req_ready, 4'b0010);
    tick();
    chk("pkt_owner2", grant_idx, 1);
    set_byte(1, 8'hA3, 1'b1);
    wait_ready("pkt_wait3");
    chk("pkt_ready3", req_ready, 4'b0010);
    tick();
    chk("pkt_owner3", grant_idx, 1);
    req_valid = 4'b0001;
    wait_ready("pkt_wait0");
    chk("pkt_ready_req0", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    wait_idle();
    chk("pkt_line0", line_mem[base + 0], 8'hA1);
    chk("pkt_line1", line_mem[base + 1], 8'hA2);
    chk("pkt_line2", line_mem[base + 2], 8'hA3);
    chk("pkt_line3", line_mem[base + 3], 8'h0E);

    // Hold timeout: req2 opens a packet and stalls, req3 waits
    do_reset();
    set_byte(2, 8'h10, 1'b0);
    set_byte(3, 8'h33, 1'b1);
    req_valid = 4'b1100;
    wait_ready("to_wait");
    chk("to_ready", req_ready, 4'b0100);
    tick();
    req_valid = 4'b1000;
    n = 0;
    while (!tx_busy && n < 20) begin tick(); n++; end
    n = 0;
    while (tx_busy && n < 100) begin tick(); n++; end
    tick();
    chk("to_hold_grant", grant_active, 1);
    chk("to_hold_idx", grant_idx, 2);
    chk("to_hold_data", tx_data, 8'h10);
    n = 0;
    bad = 1'b0;
    #1;
    while (!lock_abort && n < 40) begin
      if (req_ready != '0) bad = 1'b1;
      tick();
      #1;
      n++;
    end
    chk("to_abort_delay", n, 16);
    chk("to_others_ignored", bad, 0);
    tick();
    chk("to_abort_pulse", lock_abort, 0);
    chk("to_next_grant", grant_active, 1);
    chk("to_next_idx", grant_idx, 3);
    chk("to_next_data", tx_data, 8'h33);
    req_valid = '0;
    wait_idle();

    // Reset while UartTx is still shifting
    do_reset();
    set_byte(0, 8'h77, 1'b1);
    req_valid = 4'b0001;
    wait_ready("mr_wait");
    tick();
    set_byte(1, 8'h21, 1'b1);
    req_valid = 4'b0010;
    n = 0;
    while (!tx_busy && n < 20) begin tick(); n++; end
    tick();
    tick();
    chk("mr_pre_grant", grant_active, 1);
    nrst = 1'b0;
    #1;
    chk("mr_grant", grant_active, 0);
    chk("mr_data", tx_data, 0);
    chk("mr_latch", tx_latch, 0);
    chk("mr_ready", req_ready, 0);
    tick();
    nrst = 1'b1;
    bad = 1'b0;
    n = 0;
    while (tx_busy && n < 100) begin
      if (req_ready != '0) bad = 1'b1;
      tick();
      n++;
    end
    #1;
    chk("mr_no_ready_busy", bad, 0);
    chk("mr_ready_after", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    wait_idle();

    // ACK failure with tx_busy tied low
    model_en = 1'b0;
    n = 0;
    while (tx_busy && n < 50) begin tick(); n++; end
    do_reset();
    set_byte(2, 8'h2C, 1'b1);
    req_valid = 4'b0100;
    wait_ready("ack_wait");
    chk("ack_ready", req_ready, 4'b0100);
    tick();
    chk("ack_latch", tx_latch, 1);
    set_byte(3, 8'h3D, 1'b1);
    req_valid = 4'b1000;
    n = 0;
    while (!tx_err && n < 20) begin tick(); n++; end
    chk("ack_err_delay", n, 4);
    chk("ack_idle_grant", grant_active, 0);
    wait_ready("ack_next_wait");
    chk("ack_next_ready", req_ready, 4'b1000);
    tick();
    chk("ack_err_pulse", tx_err, 0);
    chk("ack_next_latch", tx_latch, 1);
    chk("ack_next_data", tx_data, 8'h3D);
    chk("ack_next_idx", grant_idx, 3);
    req_valid = '0;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
